hazard_scoreboard: RTL
======================

# hazard_scoreboard

Dual-pipe RAW/WAW hazard scoreboard between the decoder and the register controller. Tracks the in-flight writes for each of the 32 architectural registers with saturating-safe counters. Each cycle it grants or stalls the pipe-A/pipe-B issue pair so that no instruction reads a register that still has a pending write. It also serialises register-bank switches against all in-flight writes.

## Interface
- NUM_REGS, 32, architectural register count (index width 5)
- CNT_W, 4, pending-write counter width per register
- ASSIGN_LAT, 2, cycles after issue at which a direct register assignment is considered written
- clock_i  in  1  single clock, rising edge
- reset_i  in  1  asynchronous, active-low reset
- enableA_i, enableB_i  in  1  decoder issue valid per pipe; A is older than B
- pwriteA_i, preadA_i, sreadA_i, pwriteB_i, preadB_i, sreadB_i  in  1  primary-write, primary-read and secondary-read flags
- functionTypeA_i, functionTypeB_i  in  2  function type
- opcodeA_i, opcodeB_i  in  7  opcode
- primOperandA_i, primOperandB_i  in  5  primary register index
- secOperandA_i, secOperandB_i  in  16  secondary operand; bits [4:0] are the register index when sread is set
- flushBack_i  in  1  back-end flush; suppresses all grants this cycle
- wbA_i, wbB_i  in  1  execution writeback strobes
- wbAddrA_i, wbAddrB_i  in  5  writeback register index
- grantA_o, grantB_o  out  1  combinational; the instruction on that pipe is accepted this cycle
- stall_o  out  1  combinational; the decoder must hold both pipes (equals enableA_i & ~grantA_o | enableB_i & ~grantB_o)
- busy_o  out  1  registered; any counter nonzero or any assign-release stage valid
- stallCount_o  out  16  registered; saturating count of cycles with stall_o=1
- errorA_o, errorB_o  out  1  registered, sticky; writeback to a register whose counter is 0

## Operation
- A register assignment is functionType 1 with opcode 10 or 0 and pwrite set. A bank instruction is functionType 3 with opcode 20 or 21.
- Sources:
  - prim is a source when pread is set.
  - secOperand[4:0] is a source when sread is set.
- Pipe A hazard:
  - any source counter is nonzero, or
  - pwrite is set and the destination counter is at least 2^CNT_W-3, or
  - A is a bank instruction and busy_o is 1.
- grantA_o = enableA_i & ~hazardA & ~flushBack_i.
- Pipe B hazard: any A-hazard condition applied to B, plus:
  - enableA_i & ~grantA_o (in-order issue; B never passes A),
  - A granted with pwrite and destination equal to a B source (intra-pair RAW),
  - A granted with pwrite and B is a bank instruction.
- grantB_o = enableB_i & ~hazardB & ~flushBack_i.
- Counter update per register per cycle: next = cnt + incA + incB − decWbA − decWbB − decAsgA − decAsgB.
  - Range of a single-cycle delta is −4..+2. Compute in CNT_W+2 signed bits.
  - incX: pipe X granted with pwrite to that register. A and B writing the same register gives +2.
  - decWbX: wbX_i to that register while cnt > 0. If cnt = 0, the decrement is dropped and errorX_o is set.
- Register assignments allocate like any write. The block releases them itself: a per-pipe ASSIGN_LAT-deep shift pipe of {valid, addr} produces decAsgX when the entry exits. Writebacks are not expected for assignments.
- Bank instructions do not allocate and are granted only when busy_o is 0.
- flushBack_i blocks grants only. Counters, the assign pipes and writebacks continue unchanged.

## Timing
- Hazard checks use the registered counters, so a writeback in cycle N unblocks a dependent issue in cycle N+1 at the earliest (one-cycle issue-to-issue gap minimum).
- Counter, assign-pipe, busy_o, stallCount_o and error updates occur on the rising edge.
- Reset (async, any time, including mid-stall) clears:
  - all counters and assign pipes,
  - busy_o=0, stallCount_o=0, errorA_o=errorB_o=0.
  - Grants then depend only on inputs.
- stallCount_o holds at 0xFFFF.

## Structure
- Shared package pa_pkg:
  - FT_LOADSTORE=1, FT_BANK=3,
  - OP_ASSIGN0=0, OP_ASSIGN=10, OP_BANKINC=20, OP_BANKDEC=21,
  - NUM_REGS, CNT_W.
- One sub-module, scoreboard_counter: holds one register's counter and takes inc/dec vectors and the wb-zero error flag. It is instantiated NUM_REGS times via generate.
- Hazard and grant logic, the assign-release pipes and the stall counter live at top level.

## Test plan
- Independent pair: A writes r3, B reads r4 → grantA=grantB=1; cnt[r3]=1; a later wbA_i to r3 → cnt[r3]=0, busy_o=0 next cycle.
- Intra-pair RAW: A writes r5, B reads r5 via sread (secOperand=0x0005) → grantA=1, grantB=0, stall_o=1. The next cycle B re-presented alone still stalls until the r5 writeback, then grants one cycle after it.
- Assign release: A performs a register assignment to r7 (ft1, op10, pwrite) → cnt[r7]=1 for 2 cycles, then 0 with no writeback. A reader of r7 grants in cycle 3.
- Bank serialisation: with cnt[r1]=1, A issues op20/ft3 → held. Once wb to r1 arrives, the grant occurs in the following cycle.
- Boundaries:
  - both pipes write r9 with cnt=12 → +2 accepted (14);
  - a further write to r9 → stalled;
  - wb to r2 at cnt=0 → errorA_o=1 sticky, cnt stays 0;
  - flushBack_i=1 → grants 0, counters untouched.
- Async reset asserted mid-stall with counters nonzero → all outputs at reset values immediately. stallCount_o increments again after release.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Purpose : shared types, opcode constants and decode helpers for the hazard scoreboard.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package pa_pkg;

  localparam int NUM_REGS   = 32;
  localparam int REG_W      = 5;
  localparam int CNT_W      = 4;
  localparam int ASSIGN_LAT = 2;

  localparam logic [1:0] FT_LOADSTORE = 2'd1;
  localparam logic [1:0] FT_BANK      = 2'd3;

  localparam logic [6:0] OP_ASSIGN0 = 7'd0;
  localparam logic [6:0] OP_ASSIGN  = 7'd10;
  localparam logic [6:0] OP_BANKINC = 7'd20;
  localparam logic [6:0] OP_BANKDEC = 7'd21;

  // A destination at or above this count is treated as full, leaving headroom
  // for the +2 that a same-register dual write can add in one cycle.
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'((1 << CNT_W) - 3);

  typedef struct packed {
    logic        enable;
    logic        pwrite;
    logic        pread;
    logic        sread;
    logic [1:0]  functionType;
    logic [6:0]  opcode;
    logic [4:0]  primOperand;
    logic [15:0] secOperand;
  } issue_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] addr;
  } asgEntry_t;

  function automatic logic isAssign(issue_t ins);
    return ins.pwrite && (ins.functionType == FT_LOADSTORE) &&
           ((ins.opcode == OP_ASSIGN) || (ins.opcode == OP_ASSIGN0));
  endfunction

  function automatic logic isBank(issue_t ins);
    return (ins.functionType == FT_BANK) &&
           ((ins.opcode == OP_BANKINC) || (ins.opcode == OP_BANKDEC));
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Purpose : decoder/writeback-side bundle of the hazard scoreboard.
// Latency : n/a (wires only).
// Backpressure: grant/stall flow back to the decoder through this bundle.
// Ports   : master = decoder/exec side (drives issue, flush, writeback);
//           slave  = scoreboard (drives grants, stall, busy, stall count, errors).
interface hazard_scoreboard_if;
  import pa_pkg::*;

  logic             enableA_i, enableB_i;
  logic             pwriteA_i, preadA_i, sreadA_i;
  logic             pwriteB_i, preadB_i, sreadB_i;
  logic [1:0]       functionTypeA_i, functionTypeB_i;
  logic [6:0]       opcodeA_i, opcodeB_i;
  logic [REG_W-1:0] primOperandA_i, primOperandB_i;
  logic [15:0]      secOperandA_i, secOperandB_i;
  logic             flushBack_i;
  logic             wbA_i, wbB_i;
  logic [REG_W-1:0] wbAddrA_i, wbAddrB_i;
  logic             grantA_o, grantB_o;
  logic             stall_o;
  logic             busy_o;
  logic [15:0]      stallCount_o;
  logic             errorA_o, errorB_o;

  modport master (
    output enableA_i, enableB_i, pwriteA_i, preadA_i, sreadA_i,
           pwriteB_i, preadB_i, sreadB_i, functionTypeA_i, functionTypeB_i,
           opcodeA_i, opcodeB_i, primOperandA_i, primOperandB_i,
           secOperandA_i, secOperandB_i, flushBack_i,
           wbA_i, wbB_i, wbAddrA_i, wbAddrB_i,
    input  grantA_o, grantB_o, stall_o, busy_o, stallCount_o, errorA_o, errorB_o
  );

  modport slave (
    input  enableA_i, enableB_i, pwriteA_i, preadA_i, sreadA_i,
           pwriteB_i, preadB_i, sreadB_i, functionTypeA_i, functionTypeB_i,
           opcodeA_i, opcodeB_i, primOperandA_i, primOperandB_i,
           secOperandA_i, secOperandB_i, flushBack_i,
           wbA_i, wbB_i, wbAddrA_i, wbAddrB_i,
    output grantA_o, grantB_o, stall_o, busy_o, stallCount_o, errorA_o, errorB_o
  );

endinterface

// File: rtl/hazard_scoreboard_counter.sv
// Purpose : pending-write counter for one architectural register.
// Latency : count updates on the rising edge; cntNext/wbZeroErr are combinational.
// Backpressure: none; a writeback seen at count 0 is dropped and flagged instead.
// Ports   : incVec/wbVec/asgVec are {pipeB, pipeA} hit vectors for this register;
//           cnt is the registered count, cntNext the value loaded at the next edge.
module scoreboard_counter
  import pa_pkg::*;
(
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic [1:0]       incVec,
  input  logic [1:0]       wbVec,
  input  logic [1:0]       asgVec,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cntNext,
  output logic [1:0]       wbZeroErr
);

  // One cycle moves the count by -4..+2, so two extra bits hold the
  // two's-complement sum without wrapping.
  localparam int SUM_W = CNT_W + 2;

  logic             cntZero;
  logic [1:0]       wbDec;
  logic [SUM_W-1:0] sum;

  always_comb begin
    cntZero   = (cnt == '0);
    wbZeroErr = wbVec & {2{cntZero}};
    wbDec     = wbVec & {2{~cntZero}};
    sum       = {2'b00, cnt}
              + SUM_W'(incVec[0]) + SUM_W'(incVec[1])
              - SUM_W'(wbDec[0])  - SUM_W'(wbDec[1])
              - SUM_W'(asgVec[0]) - SUM_W'(asgVec[1]);
    // Clamp: a double writeback or a stray release can never wrap the count.
    if (sum[SUM_W-1]) begin
      cntNext = '0;
    end else if (sum[CNT_W]) begin
      cntNext = '1;
    end else begin
      cntNext = sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt <= '0;
    end else begin
      cnt <= cntNext;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Purpose : dual-pipe RAW/WAW scoreboard granting or stalling the A/B issue pair.
// Latency : grants/stall combinational from registered counters; a writeback
//           unblocks a dependent issue one cycle later.
// Backpressure: stall_o holds both pipes; B never issues past a stalled A.
// Ports   : clock_i/reset_i (async active-low), bus = slave side of the issue,
//           flush and writeback bundle carrying grants, stall, busy, stall count, errors.
module hazard_scoreboard
  import pa_pkg::*;
(
  input  logic              clock_i,
  input  logic              reset_i,
  hazard_scoreboard_if.slave bus
);

  issue_t           insA, insB;
  logic             hazardA, hazardB;
  logic             grantA, grantB, stall;
  logic             allocA, allocB;
  logic             intraRaw, intraBank;
  logic             busyQ, busyNext;
  logic [15:0]      stallCountQ;
  logic             errorAQ, errorBQ, errNextA, errNextB;

  logic [CNT_W-1:0] cnt       [NUM_REGS];
  logic [CNT_W-1:0] cntNext   [NUM_REGS];
  logic [1:0]       wbZeroErr [NUM_REGS];

  // Index 0 = pipe A, 1 = pipe B.
  asgEntry_t        asgQ   [2][ASSIGN_LAT];
  asgEntry_t        asgD   [2][ASSIGN_LAT];
  asgEntry_t        asgOut [2];

  assign insA = '{enable: bus.enableA_i, pwrite: bus.pwriteA_i, pread: bus.preadA_i,
                  sread: bus.sreadA_i, functionType: bus.functionTypeA_i,
                  opcode: bus.opcodeA_i, primOperand: bus.primOperandA_i,
                  secOperand: bus.secOperandA_i};
  assign insB = '{enable: bus.enableB_i, pwrite: bus.pwriteB_i, pread: bus.preadB_i,
                  sread: bus.sreadB_i, functionType: bus.functionTypeB_i,
                  opcode: bus.opcodeB_i, primOperand: bus.primOperandB_i,
                  secOperand: bus.secOperandB_i};

  function automatic logic baseHazard(issue_t ins, logic [CNT_W-1:0] cntPrim,
                                      logic [CNT_W-1:0] cntSec, logic busy);
    return (ins.pread  && (cntPrim != '0)) ||
           (ins.sread  && (cntSec  != '0)) ||
           (ins.pwrite && (cntPrim >= CNT_LIMIT)) ||
           (isBank(ins) && busy);
  endfunction

  always_comb begin
    hazardA = baseHazard(insA, cnt[insA.primOperand],
                         cnt[insA.secOperand[REG_W-1:0]], busyQ);
    grantA  = insA.enable && !hazardA && !bus.flushBack_i;

    // Same-cycle hazards against the older pipe are invisible in the counters,
    // so they are checked against A's decoded fields directly.
    intraRaw  = grantA && insA.pwrite &&
                ((insB.pread && (insB.primOperand == insA.primOperand)) ||
                 (insB.sread && (insB.secOperand[REG_W-1:0] == insA.primOperand)));
    intraBank = grantA && insA.pwrite && isBank(insB);
    hazardB   = baseHazard(insB, cnt[insB.primOperand],
                           cnt[insB.secOperand[REG_W-1:0]], busyQ) ||
                (insA.enable && !grantA) || intraRaw || intraBank;
    grantB    = insB.enable && !hazardB && !bus.flushBack_i;

    stall  = (insA.enable && !grantA) || (insB.enable && !grantB);
    // Bank instructions serialise but never own a register.
    allocA = insA.pwrite && !isBank(insA);
    allocB = insB.pwrite && !isBank(insB);
  end

  // Assignments have no writeback; a fixed-depth pipe releases them instead.
  always_comb begin
    asgD[0][0] = '{valid: grantA && isAssign(insA), addr: insA.primOperand};
    asgD[1][0] = '{valid: grantB && isAssign(insB), addr: insB.primOperand};
    for (int p = 0; p < 2; p++) begin
      for (int k = 1; k < ASSIGN_LAT; k++) begin
        asgD[p][k] = asgQ[p][k-1];
      end
      asgOut[p] = asgQ[p][ASSIGN_LAT-1];
    end
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : gReg
    localparam logic [REG_W-1:0] IDX = REG_W'(r);
    logic [1:0] incVec, wbVec, asgVec;

    assign incVec = {grantB && allocB && (insB.primOperand == IDX),
                     grantA && allocA && (insA.primOperand == IDX)};
    assign wbVec  = {bus.wbB_i && (bus.wbAddrB_i == IDX),
                     bus.wbA_i && (bus.wbAddrA_i == IDX)};
    assign asgVec = {asgOut[1].valid && (asgOut[1].addr == IDX),
                     asgOut[0].valid && (asgOut[0].addr == IDX)};

    scoreboard_counter uCounter (
      .clock_i   (clock_i),
      .reset_i   (reset_i),
      .incVec    (incVec),
      .wbVec     (wbVec),
      .asgVec    (asgVec),
      .cnt       (cnt[r]),
      .cntNext   (cntNext[r]),
      .wbZeroErr (wbZeroErr[r])
    );
  end

  // busy_o reflects the post-edge state so a wb in cycle N frees a bank op in N+1.
  always_comb begin
    busyNext = 1'b0;
    errNextA = errorAQ;
    errNextB = errorBQ;
    for (int r = 0; r < NUM_REGS; r++) begin
      busyNext = busyNext | (cntNext[r] != '0);
      errNextA = errNextA | wbZeroErr[r][0];
      errNextB = errNextB | wbZeroErr[r][1];
    end
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < ASSIGN_LAT; k++) begin
        busyNext = busyNext | asgD[p][k].valid;
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      busyQ       <= 1'b0;
      stallCountQ <= '0;
      errorAQ     <= 1'b0;
      errorBQ     <= 1'b0;
      for (int p = 0; p < 2; p++) begin
        for (int k = 0; k < ASSIGN_LAT; k++) begin
          asgQ[p][k] <= '0;
        end
      end
    end else begin
      busyQ   <= busyNext;
      errorAQ <= errNextA;
      errorBQ <= errNextB;
      if (stall && (stallCountQ != 16'hFFFF)) begin
        stallCountQ <= stallCountQ + 16'd1;
      end
      for (int p = 0; p < 2; p++) begin
        for (int k = 0; k < ASSIGN_LAT; k++) begin
          asgQ[p][k] <= asgD[p][k];
        end
      end
    end
  end

  assign bus.grantA_o     = grantA;
  assign bus.grantB_o     = grantB;
  assign bus.stall_o      = stall;
  assign bus.busy_o       = busyQ;
  assign bus.stallCount_o = stallCountQ;
  assign bus.errorA_o     = errorAQ;
  assign bus.errorB_o     = errorBQ;

endmodule
